// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter and its return-path router:
// default entry-field widths and the one-hot-to-index encoder both blocks use.
package arb_pkg;

  localparam int unsigned ARB_REQUESTER_NUM_DEF   = 4;
  localparam int unsigned ARB_NUM_GRANT_REQ_W_DEF = 3;
  localparam int unsigned ARB_ORDER_DEPTH_DEF     = 8;
  localparam int unsigned ARB_IDX_W_DEF           = $clog2(ARB_REQUESTER_NUM_DEF);
  localparam int unsigned ARB_ONEHOT_MAX_W        = 32;

  // Non-one-hot vectors resolve to the lowest set bit; all-zero yields 0.
  function automatic int unsigned onehot_to_idx(input logic [ARB_ONEHOT_MAX_W-1:0] onehot);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < ARB_ONEHOT_MAX_W; i++) begin
      if (onehot[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_order_fifo.sv
// Order queue: synchronous FIFO with wrap-bit pointers, full/empty/occupancy status.
module arb_order_fifo #(
  parameter  int P_WIDTH = 8,
  parameter  int P_DEPTH = 8,
  localparam int AW      = $clog2(P_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [P_WIDTH-1:0] wdata_i,
  output logic [P_WIDTH-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [AW:0]        occupancy_o
);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic               do_push;
  logic               do_pop;

  assign occupancy_o = wr_ptr_q - rd_ptr_q;
  assign full_o      = (occupancy_o == (AW+1)'(P_DEPTH));
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign rdata_o     = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/arb_grant_return_router.sv
// Records arbiter grants in order and steers the shared response stream back to the
// granted requester, popping each grant on its final beat.
module arb_grant_return_router
  import arb_pkg::*;
#(
  parameter  int P_REQUESTER_NUM   = ARB_REQUESTER_NUM_DEF,
  parameter  int P_NUM_GRANT_REQ_W = ARB_NUM_GRANT_REQ_W_DEF,
  parameter  int P_ORDER_DEPTH     = ARB_ORDER_DEPTH_DEF,
  localparam int REQ_NUM_W         = $clog2(P_REQUESTER_NUM),
  localparam int OCC_W             = $clog2(P_ORDER_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [P_REQUESTER_NUM-1:0]   grant_valid_i,
  input  logic                         grant_ready_i,
  input  logic [P_NUM_GRANT_REQ_W-1:0] num_grant_req_i,
  output logic                         order_ready_o,
  input  logic                         rsp_valid_i,
  output logic                         rsp_ready_o,
  output logic [P_REQUESTER_NUM-1:0]   rsp_valid_o,
  input  logic [P_REQUESTER_NUM-1:0]   rsp_ready_i,
  output logic                         rsp_last_o,
  output logic [REQ_NUM_W-1:0]         head_idx_o,
  output logic [OCC_W-1:0]             occupancy_o,
  output logic                         err_overflow_o,
  output logic                         err_unexpected_o
);

  localparam int ENTRY_W = REQ_NUM_W + P_NUM_GRANT_REQ_W;

  logic                         push;
  logic                         pop;
  logic                         beat;
  logic                         full;
  logic                         empty;
  logic [REQ_NUM_W-1:0]         grant_idx;
  logic [ENTRY_W-1:0]           wr_entry;
  logic [ENTRY_W-1:0]           head_entry;
  logic [REQ_NUM_W-1:0]         head_idx;
  logic [P_NUM_GRANT_REQ_W-1:0] head_beats;
  logic [P_NUM_GRANT_REQ_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                         err_overflow_q, err_overflow_d;
  logic                         err_unexpected_q, err_unexpected_d;

  assign push      = grant_ready_i & (|grant_valid_i);
  assign grant_idx = REQ_NUM_W'(onehot_to_idx(ARB_ONEHOT_MAX_W'(grant_valid_i)));
  assign wr_entry  = {grant_idx, num_grant_req_i};

  arb_order_fifo #(
    .P_WIDTH (ENTRY_W),
    .P_DEPTH (P_ORDER_DEPTH)
  ) u_order_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (wr_entry),
    .rdata_o     (head_entry),
    .full_o      (full),
    .empty_o     (empty),
    .occupancy_o (occupancy_o)
  );

  assign head_idx   = empty ? '0 : head_entry[P_NUM_GRANT_REQ_W +: REQ_NUM_W];
  assign head_beats = head_entry[P_NUM_GRANT_REQ_W-1:0];

  assign order_ready_o = ~full;
  assign head_idx_o    = head_idx;
  assign rsp_ready_o   = ~empty & rsp_ready_i[head_idx];
  assign rsp_last_o    = ~empty & (beat_cnt_q == head_beats);
  assign beat          = rsp_valid_i & rsp_ready_o;
  assign pop           = beat & rsp_last_o;

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
      rsp_valid_o[i] = ~empty & rsp_valid_i & (head_idx == REQ_NUM_W'(i));
    end
  end

  always_comb begin
    beat_cnt_d       = beat_cnt_q;
    if (beat) beat_cnt_d = rsp_last_o ? '0 : beat_cnt_q + 1'b1;
    // A simultaneous pop makes room, so only an unpaired push at full is lost.
    err_overflow_d   = push & full & ~pop;
    err_unexpected_d = rsp_valid_i & empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q       <= '0;
      err_overflow_q   <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else begin
      beat_cnt_q       <= beat_cnt_d;
      err_overflow_q   <= err_overflow_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  assign err_overflow_o   = err_overflow_q;
  assign err_unexpected_o = err_unexpected_q;

endmodule

// File: tb/tb_arb_grant_return_router.sv
// Directed self-checking bench for the grant return router (default parameters).
module tb_arb_grant_return_router;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] grant_valid_i;
  logic       grant_ready_i;
  logic [2:0] num_grant_req_i;
  logic       order_ready_o;
  logic       rsp_valid_i;
  logic       rsp_ready_o;
  logic [3:0] rsp_valid_o;
  logic [3:0] rsp_ready_i;
  logic       rsp_last_o;
  logic [1:0] head_idx_o;
  logic [3:0] occupancy_o;
  logic       err_overflow_o;
  logic       err_unexpected_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arb_grant_return_router #(
    .P_REQUESTER_NUM   (4),
    .P_NUM_GRANT_REQ_W (3),
    .P_ORDER_DEPTH     (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .grant_valid_i    (grant_valid_i),
    .grant_ready_i    (grant_ready_i),
    .num_grant_req_i  (num_grant_req_i),
    .order_ready_o    (order_ready_o),
    .rsp_valid_i      (rsp_valid_i),
    .rsp_ready_o      (rsp_ready_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_last_o       (rsp_last_o),
    .head_idx_o       (head_idx_o),
    .occupancy_o      (occupancy_o),
    .err_overflow_o   (err_overflow_o),
    .err_unexpected_o (err_unexpected_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".order_ready"}, 32'(order_ready_o), 1);
    chk({tag, ".rsp_valid"},   32'(rsp_valid_o), 0);
    chk({tag, ".rsp_ready"},   32'(rsp_ready_o), 0);
    chk({tag, ".rsp_last"},    32'(rsp_last_o), 0);
    chk({tag, ".head_idx"},    32'(head_idx_o), 0);
    chk({tag, ".occupancy"},   32'(occupancy_o), 0);
    chk({tag, ".err_ovf"},     32'(err_overflow_o), 0);
    chk({tag, ".err_unexp"},   32'(err_unexpected_o), 0);
  endtask

  task automatic push_grant(input logic [3:0] g, input logic [2:0] n);
    grant_valid_i   = g;
    grant_ready_i   = 1'b1;
    num_grant_req_i = n;
    step();
    grant_valid_i   = '0;
    grant_ready_i   = 1'b0;
    num_grant_req_i = '0;
  endtask

  initial begin
    logic [3:0] exp_v [7];
    logic       exp_l [7];
    exp_v = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0001};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    grant_valid_i = '0; grant_ready_i = 1'b0; num_grant_req_i = '0;
    rsp_valid_i = 1'b0; rsp_ready_i = '0;
    #12;
    chk_reset_vals("reset");
    #10 rst_n = 1'b1;
    step();

    // Single grant
    push_grant(4'b0100, 3'd0);
    chk("single.occ1", 32'(occupancy_o), 1);
    chk("single.head", 32'(head_idx_o), 2);
    rsp_valid_i = 1'b1; rsp_ready_i = 4'b0100;
    #1;
    chk("single.rsp_valid", 32'(rsp_valid_o), 32'h4);
    chk("single.rsp_ready", 32'(rsp_ready_o), 1);
    chk("single.last", 32'(rsp_last_o), 1);
    step();
    rsp_valid_i = 1'b0; rsp_ready_i = '0;
    #1;
    chk("single.occ0", 32'(occupancy_o), 0);
    chk("single.head0", 32'(head_idx_o), 0);

    // Burst ordering, no idle cycle between grants
    push_grant(4'b0010, 3'd3);
    push_grant(4'b1000, 3'd1);
    push_grant(4'b0001, 3'd0);
    chk("burst.occ3", 32'(occupancy_o), 3);
    rsp_valid_i = 1'b1; rsp_ready_i = 4'b1111;
    for (int b = 0; b < 7; b++) begin
      #1;
      chk($sformatf("burst.valid%0d", b), 32'(rsp_valid_o), 32'(exp_v[b]));
      chk($sformatf("burst.last%0d", b), 32'(rsp_last_o), 32'(exp_l[b]));
      step();
    end
    rsp_valid_i = 1'b0; rsp_ready_i = '0;
    #1;
    chk("burst.occ0", 32'(occupancy_o), 0);

    // Backpressure on requester 2 for 5 cycles
    push_grant(4'b0100, 3'd1);
    rsp_valid_i = 1'b1; rsp_ready_i = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp.ready%0d", c), 32'(rsp_ready_o), 0);
      chk($sformatf("bp.valid%0d", c), 32'(rsp_valid_o), 32'h4);
      chk($sformatf("bp.last%0d", c), 32'(rsp_last_o), 0);
      step();
    end
    rsp_ready_i = 4'b1111;
    #1;
    chk("bp.beat1.last", 32'(rsp_last_o), 0);
    step();
    chk("bp.beat2.last", 32'(rsp_last_o), 1);
    chk("bp.beat2.occ", 32'(occupancy_o), 1);
    step();
    rsp_valid_i = 1'b0; rsp_ready_i = '0;
    #1;
    chk("bp.occ0", 32'(occupancy_o), 0);

    // Fill, overflow, then simultaneous push/pop at 7
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("full.ready_before", 32'(order_ready_o), 1);
      push_grant(4'(1 << (i % 4)), 3'd0);
    end
    chk("full.ready", 32'(order_ready_o), 0);
    chk("full.occ8", 32'(occupancy_o), 8);
    push_grant(4'b0010, 3'd0);
    chk("ovf.pulse", 32'(err_overflow_o), 1);
    chk("ovf.occ8", 32'(occupancy_o), 8);
    step();
    chk("ovf.pulse_end", 32'(err_overflow_o), 0);
    rsp_valid_i = 1'b1; rsp_ready_i = 4'b1111;
    #1;
    chk("full.pop.head", 32'(head_idx_o), 0);
    step();
    rsp_valid_i = 1'b0;
    #1;
    chk("full.pop.occ7", 32'(occupancy_o), 7);
    chk("full.pop.ready", 32'(order_ready_o), 1);
    chk("full.pop.head1", 32'(head_idx_o), 1);
    rsp_valid_i = 1'b1;
    push_grant(4'b0100, 3'd0);
    rsp_valid_i = 1'b0;
    #1;
    chk("pushpop.occ7", 32'(occupancy_o), 7);
    chk("pushpop.head2", 32'(head_idx_o), 2);
    chk("pushpop.no_ovf", 32'(err_overflow_o), 0);
    rsp_valid_i = 1'b1;
    for (int i = 0; i < 7; i++) step();
    rsp_valid_i = 1'b0; rsp_ready_i = '0;
    #1;
    chk("drain.occ0", 32'(occupancy_o), 0);

    // Unexpected response while empty
    rsp_valid_i = 1'b1; rsp_ready_i = 4'b1111;
    #1;
    chk("unexp.rsp_ready", 32'(rsp_ready_o), 0);
    chk("unexp.rsp_valid", 32'(rsp_valid_o), 0);
    step();
    rsp_valid_i = 1'b0; rsp_ready_i = '0;
    chk("unexp.pulse", 32'(err_unexpected_o), 1);
    step();
    chk("unexp.pulse_end", 32'(err_unexpected_o), 0);

    // Asynchronous reset mid-burst
    push_grant(4'b1000, 3'd3);
    rsp_valid_i = 1'b1; rsp_ready_i = 4'b1111;
    #1;
    chk("rstmid.beat1.valid", 32'(rsp_valid_o), 32'h8);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("rstmid");
    rsp_valid_i = 1'b0; rsp_ready_i = '0;
    #1 rst_n = 1'b1;
    step();
    push_grant(4'b0010, 3'd1);
    rsp_valid_i = 1'b1; rsp_ready_i = 4'b0010;
    #1;
    chk("after_rst.valid", 32'(rsp_valid_o), 32'h2);
    chk("after_rst.last1", 32'(rsp_last_o), 0);
    step();
    chk("after_rst.last2", 32'(rsp_last_o), 1);
    step();
    rsp_valid_i = 1'b0; rsp_ready_i = '0;
    #1;
    chk("after_rst.occ0", 32'(occupancy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
